// File: rtl/wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
//   XLEN  : register data width
//   NREG  : number of architectural registers (x0 is hardwired to zero)
//   REG_W : register index width
//   wb_req_t : one writeback request (destination index + data)
package wb_pkg;

  localparam int XLEN  = 64;
  localparam int NREG  = 32;
  localparam int REG_W = 5;

  // "reg" is a reserved word, so the destination field is called dst.
  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  val;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request lines (bit 0 = ALU, bit 1 = load unit)
//   gnt[1:0]   : one-hot grant, combinational from req and the pointer
// The priority pointer only moves on contended cycles, so a lone requester
// never steals priority from the other side.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // ptr_q == 0 favours req[0], ptr_q == 1 favours req[1]
  logic ptr_q;
  logic ptr_d;

  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (!reset) begin
      if (req == 2'b11) begin
        gnt   = ptr_q ? 2'b10 : 2'b01;
        ptr_d = ~ptr_q;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter with destination scoreboard.
//   clk, reset              : clock, synchronous active-high reset
//   alu_valid/ready/reg/val : ALU writeback request channel
//   ld_valid/ready/reg/val  : load-unit writeback request channel
//   rsv_valid, rsv_reg      : decode reserving a destination register
//   wr_en, wr_reg, wr_val   : registered register-file write port (latency 1)
//   busy[31:0]              : per-register pending-write mask, bit 0 always 0
// One request is accepted per cycle via rr_arb2; the accepted request is
// registered onto the write port. Writes to x0 are consumed silently.
module regfile_wb_arbiter
  import wb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [REG_W-1:0] alu_reg,
  input  logic [XLEN-1:0]  alu_val,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [REG_W-1:0] ld_reg,
  input  logic [XLEN-1:0]  ld_val,
  input  logic             rsv_valid,
  input  logic [REG_W-1:0] rsv_reg,
  output logic             wr_en,
  output logic [REG_W-1:0] wr_reg,
  output logic [XLEN-1:0]  wr_val,
  output logic [NREG-1:0]  busy
);

  logic [1:0] gnt;
  wb_req_t    sel;

  logic             wr_en_q,  wr_en_d;
  logic [REG_W-1:0] wr_reg_q, wr_reg_d;
  logic [XLEN-1:0]  wr_val_q, wr_val_d;
  logic [NREG-1:0]  busy_q,   busy_d;

  // Arbiter also masks grants while reset is high.
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({ld_valid, alu_valid}),
    .gnt   (gnt)
  );

  assign alu_ready = gnt[0];
  assign ld_ready  = gnt[1];

  always_comb begin
    sel      = '0;
    wr_en_d  = 1'b0;
    wr_reg_d = '0;
    wr_val_d = '0;

    if (gnt[0]) begin
      sel.dst = alu_reg;
      sel.val = alu_val;
    end else if (gnt[1]) begin
      sel.dst = ld_reg;
      sel.val = ld_val;
    end

    // x0 requests are accepted but never reach the register file.
    if ((gnt != 2'b00) && (sel.dst != '0)) begin
      wr_en_d  = 1'b1;
      wr_reg_d = sel.dst;
      wr_val_d = sel.val;
    end
  end

  // Clear first, then set: a reservation on the same edge as the write that
  // retires the old value belongs to a newer instruction and must survive.
  always_comb begin
    busy_d = busy_q;
    if (wr_en_q) begin
      busy_d[wr_reg_q] = 1'b0;
    end
    if (rsv_valid && (rsv_reg != '0)) begin
      busy_d[rsv_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en_q  <= 1'b0;
      wr_reg_q <= '0;
      wr_val_q <= '0;
      busy_q   <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      wr_reg_q <= wr_reg_d;
      wr_val_q <= wr_val_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_en  = wr_en_q;
  assign wr_reg = wr_reg_q;
  assign wr_val = wr_val_q;
  assign busy   = busy_q;

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 SHALL use clock clk and reset reset, synchronous, active-high.
REQ-002 Ports, one per line (name, direction, width, meaning):
 clk  in  1  clock
 reset  in  1  sync active-high reset
 alu_valid  in  1  ALU writeback request
 alu_ready  out  1  ALU request accepted this cycle
 alu_reg  in  5  ALU destination register
 alu_val  in  64  ALU result
 ld_valid  in  1  load-unit writeback request
 ld_ready  out  1  load request accepted this cycle
 ld_reg  in  5  load destination register
 ld_val  in  64  load data
 rsv_valid  in  1  decode reserves a destination
 rsv_reg  in  5  register being reserved
 wr_en  out  1  register-file write enable
 wr_reg  out  5  register-file write index
 wr_val  out  64  register-file write data
 busy  out  32  per-register pending-write mask; bit 0 always 0

Function
REQ-003 SHALL accept at most one writeback request per cycle; a request is accepted when valid and ready are both high.
REQ-004 alu_ready and ld_ready SHALL be combinational from the valids and the priority pointer; ready SHALL be asserted only for the requester granted this cycle.
REQ-005 With a single valid requester, that requester SHALL be granted.
REQ-006 With both valid, the requester named by the priority pointer SHALL be granted; the pointer SHALL then point to the other requester.
REQ-007 The pointer SHALL change only on a contended cycle; after reset it SHALL favour ALU.
REQ-008 An accepted request SHALL appear on wr_en/wr_reg/wr_val exactly one cycle later (registered outputs, latency 1).
REQ-009 wr_en SHALL be high for exactly one cycle per accepted request with nonzero destination.
REQ-010 A request to register 0 SHALL be accepted and consumed, but SHALL NOT raise wr_en and SHALL NOT affect busy.
REQ-011 When wr_en is low, wr_reg and wr_val SHALL be 0.
REQ-012 rsv_valid with rsv_reg nonzero SHALL set busy[rsv_reg] at the next edge; rsv_reg 0 SHALL be ignored.
REQ-013 busy[wr_reg] SHALL clear at the edge where wr_en is high, i.e. the edge at which the register file captures the value.
REQ-014 Reservation and clear of the same register on the same edge SHALL leave the bit set (newer reservation wins).
REQ-015 Requests from both sources to the same register SHALL be serialized in grant order and never merged.
REQ-016 Writing a register whose busy bit is already clear SHALL be legal and leave the bit clear.

Reset
REQ-017 On reset: wr_en, wr_reg and wr_val SHALL be 0; busy SHALL be all-zero; pointer SHALL favour ALU.
REQ-018 alu_ready and ld_ready SHALL be 0 while reset is high; a request in flight during reset SHALL be discarded.

Structure
REQ-019 Package wb_pkg SHALL hold XLEN=64, NREG=32, REG_W=5, and typedef wb_req_t {reg, val}.
REQ-020 Two-input round-robin arbitration SHALL live in sub-module rr_arb2 (req[1:0], gnt[1:0], pointer state inside).

Verification
REQ-021 ALU only: alu_valid=1, reg=5, val=0x1234 -> alu_ready=1 same cycle; next cycle wr_en=1, wr_reg=5, wr_val=0x1234.
REQ-022 Contention after reset, repeated 4 cycles: ALU reg=3, LD reg=4 -> grants in order ALU, LD, ALU, LD; writes issued one cycle after each grant.
REQ-023 Reserve x7, then LD writes x7 -> busy[7]=1 after the reservation edge; busy[7]=0 after the edge with wr_en=1, wr_reg=7.
REQ-024 Same edge: rsv x9 while wr_en with wr_reg=9 -> busy[9] remains 1.
REQ-025 ALU write to x0 with val=0xFFFF -> alu_ready=1, wr_en stays 0, busy unchanged.
REQ-026 Reset asserted while both valid and busy=0x000000F0 -> next cycle wr_en=0, busy=0, readies 0; after release ALU is granted first.
